pll_reg_bank: RTL



---
 rtl/pll_reg_bank.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pll_reg_bank.sv
// SPI-side register bank for the multi-channel PLL: per-channel DCO test register, double-buffered
// divider with busy-gated load, control/enables, captured DCO status and sticky clear-on-read flags.
module pll_reg_bank #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  parameter int AW     = $clog2(NUM_CH) + 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic                 i_rw,
  input  logic [AW-1:0]        i_addr,
  input  logic [DW-1:0]        i_wdata,
  output logic [DW-1:0]        o_rdata,
  output logic                 o_rd_valid,
  output logic                 o_err,
  output logic [NUM_CH*DW-1:0] o_dco_tst,
  output logic [NUM_CH*DW-1:0] o_div_val,
  output logic [2*NUM_CH-1:0]  o_div_en,
  output logic [NUM_CH-1:0]    o_div_load,
  input  logic [NUM_CH-1:0]    i_div_busy,
  input  logic [NUM_CH-1:0]    i_dco_upd,
  input  logic [NUM_CH*DW-1:0] i_dco_sts
);

  localparam logic [AW-1:0] CH_LIMIT   = AW'(NUM_CH);
  localparam logic [2:0]    OFF_TST    = 3'd0;
  localparam logic [2:0]    OFF_SHADOW = 3'd1;
  localparam logic [2:0]    OFF_CTRL   = 3'd2;
  localparam logic [2:0]    OFF_STS    = 3'd3;
  localparam logic [2:0]    OFF_FLAGS  = 3'd4;
  localparam logic [2:0]    OFF_ACTIVE = 3'd5;

  logic [DW-1:0]     r_tst       [NUM_CH];
  logic [DW-1:0]     r_divShadow [NUM_CH];
  logic [DW-1:0]     r_divActive [NUM_CH];
  logic [DW-1:0]     r_ctrl      [NUM_CH];
  logic [DW-1:0]     r_sts       [NUM_CH];
  logic [NUM_CH-1:0] r_loadPend;
  logic [NUM_CH-1:0] r_flagNew;
  logic [NUM_CH-1:0] r_flagOvr;
  logic [NUM_CH-1:0] r_divLoad;
  logic [DW-1:0]     r_rdata;
  logic              r_rdValid;
  logic              r_err;

  logic [AW-1:0]     w_chIdx;
  logic [2:0]        w_off;
  logic              w_inRange;
  logic              w_wrAcc;
  logic              w_rdAcc;
  logic [NUM_CH-1:0] w_chSel;
  logic [NUM_CH-1:0] w_wrTst;
  logic [NUM_CH-1:0] w_wrShadow;
  logic [NUM_CH-1:0] w_wrCtrl;
  logic [NUM_CH-1:0] w_loadReq;
  logic [NUM_CH-1:0] w_flagsRd;
  logic [NUM_CH-1:0] w_commit;
  logic [DW-1:0]     w_shadowNext [NUM_CH];
  logic [DW-1:0]     w_rdMux;

  assign w_chIdx   = i_addr >> 3;
  assign w_off     = i_addr[2:0];
  assign w_inRange = (w_chIdx < CH_LIMIT);
  assign w_wrAcc   = i_valid & i_rw & w_inRange;
  assign w_rdAcc   = i_valid & ~i_rw & w_inRange;

  // A shadow write landing on the commit cycle is forwarded so the load always takes the latest value.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_chSel[c]      = w_inRange && (w_chIdx == AW'(c));
      w_wrTst[c]      = w_wrAcc && w_chSel[c] && (w_off == OFF_TST);
      w_wrShadow[c]   = w_wrAcc && w_chSel[c] && (w_off == OFF_SHADOW);
      w_wrCtrl[c]     = w_wrAcc && w_chSel[c] && (w_off == OFF_CTRL);
      w_loadReq[c]    = w_wrCtrl[c] && i_wdata[DW-1];
      w_flagsRd[c]    = w_rdAcc && w_chSel[c] && (w_off == OFF_FLAGS);
      w_commit[c]     = r_loadPend[c] && !i_div_busy[c];
      w_shadowNext[c] = w_wrShadow[c] ? i_wdata : r_divShadow[c];
    end
  end

  always_comb begin
    w_rdMux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_chSel[c]) begin
        case (w_off)
          OFF_TST:    w_rdMux = r_tst[c];
          OFF_SHADOW: w_rdMux = r_divShadow[c];
          OFF_CTRL:   w_rdMux = r_ctrl[c];
          OFF_STS:    w_rdMux = r_sts[c];
          OFF_FLAGS:  w_rdMux = DW'({r_loadPend[c], r_flagOvr[c], r_flagNew[c]});
          OFF_ACTIVE: w_rdMux = r_divActive[c];
          default:    w_rdMux = '0;
        endcase
      end
    end
  end

  // Status capture and the flag read-clear share an edge; a same-cycle capture outranks the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_tst[c]       <= '0;
        r_divShadow[c] <= '0;
        r_divActive[c] <= '0;
        r_ctrl[c]      <= DW'(3);
        r_sts[c]       <= '0;
      end
      r_loadPend <= '0;
      r_flagNew  <= '0;
      r_flagOvr  <= '0;
      r_divLoad  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wrTst[c]) r_tst[c] <= i_wdata;
        r_divShadow[c] <= w_shadowNext[c];
        if (w_wrCtrl[c]) r_ctrl[c] <= {1'b0, i_wdata[DW-2:0]};
        if (w_commit[c]) r_divActive[c] <= w_shadowNext[c];
        if (i_dco_upd[c]) r_sts[c] <= i_dco_sts[c*DW +: DW];
      end
      r_loadPend <= (r_loadPend & ~w_commit) | (~r_loadPend & w_loadReq);
      r_flagNew  <= i_dco_upd | (r_flagNew & ~w_flagsRd);
      r_flagOvr  <= (i_dco_upd & r_flagNew) | (r_flagOvr & ~w_flagsRd);
      r_divLoad  <= w_commit;
    end
  end

  // Out-of-range reads still answer (with zero) so the SPI slave never waits on a missing response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata   <= '0;
      r_rdValid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rdValid <= i_valid & ~i_rw;
      r_err     <= i_valid & ~w_inRange;
      if (i_valid && !i_rw) r_rdata <= w_rdMux;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      o_dco_tst[c*DW +: DW] = r_tst[c];
      o_div_val[c*DW +: DW] = r_divActive[c];
      o_div_en[2*c +: 2]    = r_ctrl[c][1:0];
    end
  end

  assign o_div_load = r_divLoad;
  assign o_rdata    = r_rdata;
  assign o_rd_valid = r_rdValid;
  assign o_err      = r_err;

endmodule
